// File: rtl/spi_pkg.sv
// Shared types for the SPI master: controller state encoding and mode bit positions.
package spi_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_GAP,
        S_LEAD,
        S_XFER,
        S_TRAIL
    } spi_state_e;

    // mode port is {CPOL, CPHA}
    localparam int unsigned MODE_CPHA = 0;
    localparam int unsigned MODE_CPOL = 1;

endpackage

// File: rtl/spi_irq_sync.sv
// Peripheral interrupt capture: 2-flop synchroniser, active-edge detect and sticky pending flags.
module spi_irq_sync
    import spi_pkg::*;
#(
    parameter int unsigned NUM_IRQ = 2,
    parameter bit          ACT_LOW = 1'b1
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic [NUM_IRQ-1:0] irq_i,
    input  logic [NUM_IRQ-1:0] clear_i,
    output logic [NUM_IRQ-1:0] pending_o
);

    // Sync chain resets to the inactive level so reset release cannot fake an edge.
    localparam logic [NUM_IRQ-1:0] IDLE_LVL = {NUM_IRQ{ACT_LOW}};

    logic [NUM_IRQ-1:0] s1_q, s2_q, s3_q, pending_q;
    logic [NUM_IRQ-1:0] edge_d;

    always_comb begin
        edge_d = ACT_LOW ? (s3_q & ~s2_q) : (~s3_q & s2_q);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_q      <= IDLE_LVL;
            s2_q      <= IDLE_LVL;
            s3_q      <= IDLE_LVL;
            pending_q <= '0;
        end else begin
            s1_q      <= irq_i;
            s2_q      <= s1_q;
            s3_q      <= s2_q;
            pending_q <= (pending_q & ~clear_i) | edge_d;
        end
    end

    assign pending_o = pending_q;

endmodule

// File: rtl/spi_multi_master.sv
// SPI master with NUM_CS chip selects, per-transaction CPOL/CPHA, CS hold for bursts
// and latched peripheral interrupts.
module spi_multi_master
    import spi_pkg::*;
#(
    parameter int unsigned NUM_CS      = 2,
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned HALF_DIV    = 4,
    parameter int unsigned NUM_IRQ     = 2,
    parameter int unsigned IRQ_ACT_LOW = 1
) (
    input  logic                          clk_clk,
    input  logic                          reset_reset_n,
    input  logic                          start,
    // One spare code point so out-of-range selects stay representable and can be rejected.
    input  logic [$clog2(NUM_CS+1)-1:0]   cs_sel,
    input  logic [1:0]                    mode,
    input  logic                          hold_cs,
    input  logic [DATA_W-1:0]             tx_data,
    output logic                          busy,
    output logic                          done,
    output logic                          err,
    output logic [DATA_W-1:0]             rx_data,
    output logic                          spi_sck,
    output logic                          spi_mosi,
    input  logic                          spi_miso,
    output logic [NUM_CS-1:0]             spi_cs_n,
    input  logic [NUM_IRQ-1:0]            irq_in,
    input  logic [NUM_IRQ-1:0]            irq_clear,
    output logic [NUM_IRQ-1:0]            irq_pending
);

    localparam int unsigned CS_W   = $clog2(NUM_CS + 1);
    localparam int unsigned HALF_N = 2 * DATA_W;
    localparam int unsigned HALF_W = $clog2(HALF_N);
    localparam int unsigned DIV_W  = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;
    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(HALF_DIV - 1);
    localparam logic [HALF_W-1:0] HALF_LAST = HALF_W'(HALF_N - 1);

    spi_state_e          state_q;
    logic [DIV_W-1:0]    div_q;
    logic [HALF_W-1:0]   half_q;
    logic                sck_q, mosi_q, busy_q, done_q, err_q;
    logic                cpha_q, hold_q, held_q;
    logic [NUM_CS-1:0]   cs_n_q;
    logic [CS_W-1:0]     sel_q, held_sel_q;
    logic [DATA_W-1:0]   tx_sh_q, rx_sh_q, rx_data_q;
    logic                miso_s1_q, miso_s2_q, smp1_q, smp2_q;

    logic                tick_d, edge_d, lead_d, shift_d, sample_d;
    logic [HALF_W-1:0]   edge_idx_d;
    logic [NUM_CS-1:0]   req_mask_d, sel_mask_d;

    // edge_idx_d is the half-period about to start; even indices are leading SCK edges.
    always_comb begin
        tick_d     = (div_q == DIV_LAST);
        edge_idx_d = (state_q == S_LEAD) ? '0 : half_q + 1'b1;
        edge_d     = tick_d && ((state_q == S_LEAD) ||
                                (state_q == S_XFER && half_q != HALF_LAST));
        lead_d     = ~edge_idx_d[0];
        shift_d    = edge_d && (cpha_q ? lead_d : (!lead_d && edge_idx_d != HALF_LAST));
        sample_d   = edge_d && (cpha_q ? !lead_d : lead_d);
        req_mask_d = ~(NUM_CS'(1) << cs_sel);
        sel_mask_d = ~(NUM_CS'(1) << sel_q);
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state_q    <= S_IDLE;
            div_q      <= '0;
            half_q     <= '0;
            sck_q      <= 1'b0;
            mosi_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            cpha_q     <= 1'b0;
            hold_q     <= 1'b0;
            held_q     <= 1'b0;
            cs_n_q     <= '1;
            sel_q      <= '0;
            held_sel_q <= '0;
            tx_sh_q    <= '0;
            rx_data_q  <= '0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (start) begin
                        if (cs_sel >= CS_W'(NUM_CS)) begin
                            err_q <= 1'b1;
                        end else begin
                            busy_q <= 1'b1;
                            div_q  <= '0;
                            sel_q  <= cs_sel;
                            cpha_q <= mode[MODE_CPHA];
                            hold_q <= hold_cs;
                            held_q <= 1'b0;
                            sck_q  <= mode[MODE_CPOL];
                            if (mode[MODE_CPHA]) begin
                                mosi_q  <= 1'b0;
                                tx_sh_q <= tx_data;
                            end else begin
                                mosi_q  <= tx_data[DATA_W-1];
                                tx_sh_q <= tx_data << 1;
                            end
                            if (held_q && held_sel_q != cs_sel) begin
                                cs_n_q  <= '1;
                                state_q <= S_GAP;
                            end else begin
                                cs_n_q  <= req_mask_d;
                                state_q <= S_LEAD;
                            end
                        end
                    end
                end
                S_GAP: begin
                    if (tick_d) begin
                        div_q   <= '0;
                        cs_n_q  <= sel_mask_d;
                        state_q <= S_LEAD;
                    end else begin
                        div_q <= div_q + 1'b1;
                    end
                end
                S_LEAD: begin
                    if (tick_d) begin
                        div_q   <= '0;
                        half_q  <= '0;
                        sck_q   <= ~sck_q;
                        state_q <= S_XFER;
                    end else begin
                        div_q <= div_q + 1'b1;
                    end
                end
                S_XFER: begin
                    if (tick_d) begin
                        div_q <= '0;
                        if (half_q == HALF_LAST) begin
                            state_q <= S_TRAIL;
                        end else begin
                            half_q <= half_q + 1'b1;
                            sck_q  <= ~sck_q;
                        end
                    end else begin
                        div_q <= div_q + 1'b1;
                    end
                end
                S_TRAIL: begin
                    if (tick_d) begin
                        div_q     <= '0;
                        state_q   <= S_IDLE;
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                        rx_data_q <= rx_sh_q;
                        mosi_q    <= 1'b0;
                        if (hold_q) begin
                            held_q     <= 1'b1;
                            held_sel_q <= sel_q;
                        end else begin
                            cs_n_q <= '1;
                        end
                    end else begin
                        div_q <= div_q + 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
            if (shift_d) begin
                mosi_q  <= tx_sh_q[DATA_W-1];
                tx_sh_q <= tx_sh_q << 1;
            end
        end
    end

    // Capture is delayed two cycles after each sampling edge to line up with the miso
    // synchroniser, so rx bits reflect the pin level at the SCK edge itself.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            miso_s1_q <= 1'b0;
            miso_s2_q <= 1'b0;
            smp1_q    <= 1'b0;
            smp2_q    <= 1'b0;
            rx_sh_q   <= '0;
        end else begin
            miso_s1_q <= spi_miso;
            miso_s2_q <= miso_s1_q;
            smp1_q    <= sample_d;
            smp2_q    <= smp1_q;
            if (smp2_q) begin
                rx_sh_q <= {rx_sh_q[DATA_W-2:0], miso_s2_q};
            end
        end
    end

    spi_irq_sync #(
        .NUM_IRQ (NUM_IRQ),
        .ACT_LOW (IRQ_ACT_LOW != 0)
    ) u_irq_sync (
        .clk_i     (clk_clk),
        .rst_ni    (reset_reset_n),
        .irq_i     (irq_in),
        .clear_i   (irq_clear),
        .pending_o (irq_pending)
    );

    assign busy     = busy_q;
    assign done     = done_q;
    assign err      = err_q;
    assign rx_data  = rx_data_q;
    assign spi_sck  = sck_q;
    assign spi_mosi = mosi_q;
    assign spi_cs_n = cs_n_q;

endmodule

// File: tb/tb_spi_multi_master.sv
// Randomised bench for spi_multi_master: SPI slave model on the pins plus a
// transaction-level reference for latency, data and chip-select behaviour.
module tb_spi_multi_master;

    localparam int unsigned DW  = 8;
    localparam int unsigned HD  = 2;
    localparam int unsigned LAT = 1 + HD * (2 * DW + 2);

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [1:0] cs_sel;
    logic [1:0] mode;
    logic       hold_cs;
    logic [7:0] tx_data;
    logic       busy, done, err;
    logic [7:0] rx_data;
    logic       spi_sck, spi_mosi;
    logic       miso = 1'b0;
    logic [1:0] spi_cs_n;
    logic [1:0] irq_in, irq_clear, irq_pending;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    // Reference state: which CS (if any) the previous transaction left asserted.
    logic m_held    = 1'b0;
    logic m_held_cs = 1'b0;

    // Slave model state
    logic [7:0]  sl_word = '0, sl_sh = '0, sl_rx = '0;
    logic        sl_cpol = 1'b0, sl_cpha = 1'b0, sl_cs = 1'b0;
    logic        sl_prev_sck = 1'b0, sl_lead;
    int unsigned sl_nedge = 0;
    int unsigned arm_req = 0, arm_seen = 0;

    always #5 clk = ~clk;

    spi_multi_master #(
        .NUM_CS      (2),
        .DATA_W      (DW),
        .HALF_DIV    (HD),
        .NUM_IRQ     (2),
        .IRQ_ACT_LOW (1)
    ) dut (
        .clk_clk       (clk),
        .reset_reset_n (rst_n),
        .start         (start),
        .cs_sel        (cs_sel),
        .mode          (mode),
        .hold_cs       (hold_cs),
        .tx_data       (tx_data),
        .busy          (busy),
        .done          (done),
        .err           (err),
        .rx_data       (rx_data),
        .spi_sck       (spi_sck),
        .spi_mosi      (spi_mosi),
        .spi_miso      (miso),
        .spi_cs_n      (spi_cs_n),
        .irq_in        (irq_in),
        .irq_clear     (irq_clear),
        .irq_pending   (irq_pending)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Mode-aware SPI slave reacting to pin activity. A first edge that returns SCK
    // to CPOL is a re-park between words, not a clock edge.
    always @(posedge clk) begin
        #2;
        if (arm_req != arm_seen) begin
            arm_seen = arm_req;
            sl_rx    = '0;
            sl_nedge = 0;
            if (!sl_cpha) begin
                miso  = sl_word[7];
                sl_sh = {sl_word[6:0], 1'b0};
            end else begin
                sl_sh = sl_word;
            end
        end else if (!spi_cs_n[sl_cs] && spi_sck != sl_prev_sck) begin
            sl_lead = (spi_sck != sl_cpol);
            if (sl_lead || sl_nedge != 0) begin
                sl_nedge++;
                if (sl_lead != sl_cpha) begin
                    sl_rx = {sl_rx[6:0], spi_mosi};
                end else begin
                    miso  = sl_sh[7];
                    sl_sh = {sl_sh[6:0], 1'b0};
                end
            end
        end
        sl_prev_sck = spi_sck;
    end

    task automatic do_xfer(input logic cs, input logic [1:0] md, input logic hd,
                           input logic [7:0] tx, input logic [7:0] sw, input int unsigned poke_at);
        logic        gap     = m_held && (m_held_cs != cs);
        int unsigned exp_lat = LAT + (gap ? HD : 0);
        logic [1:0]  sel_n   = ~(2'b01 << cs);
        int unsigned n       = 1;
        int unsigned edges   = 0;
        logic        prev;
        sl_word = sw; sl_cpol = md[1]; sl_cpha = md[0]; sl_cs = cs;
        arm_req++;
        start = 1'b1; cs_sel = {1'b0, cs}; mode = md; hold_cs = hd; tx_data = tx;
        tick();
        start = 1'b0; tx_data = 8'($urandom); mode = 2'($urandom);
        check("c1_busy", 32'(busy), 32'd1);
        check("c1_cs_n", 32'(spi_cs_n), gap ? 32'd3 : 32'(sel_n));
        check("c1_sck", 32'(spi_sck), 32'(md[1]));
        if (!md[0]) check("c1_mosi_msb", 32'(spi_mosi), 32'(tx[7]));
        prev = spi_sck;
        while (!done && n < exp_lat + 20) begin
            if (n == poke_at) begin
                start = 1'b1; cs_sel = {1'b0, ~cs}; tx_data = ~tx; mode = ~md;
            end else begin
                start = 1'b0;
            end
            tick();
            n++;
            if (spi_sck != prev) edges++;
            prev = spi_sck;
            if (gap && n == 2) check("gap_cs_n", 32'(spi_cs_n), 32'd3);
            if (gap && n == 3) check("gap_cs_fall", 32'(spi_cs_n), 32'(sel_n));
        end
        start = 1'b0;
        check("done_seen", 32'(done), 32'd1);
        check("latency", n, exp_lat);
        check("rx_data", 32'(rx_data), 32'(sw));
        check("slave_rx", 32'(sl_rx), 32'(tx));
        check("sck_edges", edges, 2 * DW);
        check("busy_at_done", 32'(busy), 32'd0);
        check("sck_idle", 32'(spi_sck), 32'(md[1]));
        check("mosi_idle", 32'(spi_mosi), 32'd0);
        check("cs_after", 32'(spi_cs_n), hd ? 32'(sel_n) : 32'd3);
        tick();
        check("done_pulse", 32'(done), 32'd0);
        check("rx_hold", 32'(rx_data), 32'(sw));
        m_held    = hd;
        m_held_cs = cs;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic       sck_before;
        int unsigned edges;
        logic        prev;
        logic        saw_done;
        rst_n = 1'b0; start = 1'b0; cs_sel = '0; mode = '0; hold_cs = 1'b0; tx_data = '0;
        irq_in = 2'b11; irq_clear = '0;
        repeat (3) tick();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_rx", 32'(rx_data), 32'd0);
        check("rst_sck", 32'(spi_sck), 32'd0);
        check("rst_mosi", 32'(spi_mosi), 32'd0);
        check("rst_cs_n", 32'(spi_cs_n), 32'd3);
        check("rst_irq", 32'(irq_pending), 32'd0);
        rst_n = 1'b1;
        repeat (2) tick();

        do_xfer(1'b1, 2'b00, 1'b0, 8'hA5, 8'h3C, 0);
        for (int m = 1; m < 4; m++) do_xfer(1'($urandom_range(0, 1)), 2'(m), 1'b0, 8'h81, 8'h7E, 0);

        do_xfer(1'b0, 2'b00, 1'b1, 8'h11, 8'($urandom), 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("burst_idle_cs", 32'(spi_cs_n), 32'd2);
        end
        do_xfer(1'b0, 2'b00, 1'b0, 8'h22, 8'($urandom), 0);

        do_xfer(1'b0, 2'($urandom), 1'b1, 8'($urandom), 8'($urandom), 0);
        do_xfer(1'b1, 2'($urandom), 1'b0, 8'($urandom), 8'($urandom), 0);

        sck_before = spi_sck;
        start = 1'b1; cs_sel = 2'd2; mode = 2'b11; tx_data = 8'hFF;
        tick();
        start = 1'b0;
        check("err_pulse", 32'(err), 32'd1);
        check("err_busy", 32'(busy), 32'd0);
        check("err_cs_n", 32'(spi_cs_n), 32'd3);
        check("err_sck", 32'(spi_sck), 32'(sck_before));
        tick();
        check("err_one_cycle", 32'(err), 32'd0);
        edges = 0; prev = spi_sck;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (spi_sck != prev) edges++;
            prev = spi_sck;
        end
        check("err_no_sck", edges, 0);
        check("err_idle_busy", 32'(busy), 32'd0);

        do_xfer(1'b1, 2'b11, 1'b0, 8'h5A, 8'hC3, 10);

        for (int i = 0; i < 12; i++)
            do_xfer(1'($urandom_range(0, 1)), 2'($urandom), 1'($urandom_range(0, 1)),
                    8'($urandom), 8'($urandom), 0);

        irq_in[1] = 1'b0;
        tick(); check("irq_lat1", 32'(irq_pending), 32'd0);
        tick(); check("irq_lat2", 32'(irq_pending), 32'd0);
        tick(); check("irq_set", 32'(irq_pending), 32'd2);
        irq_in[0] = 1'b0;
        tick(); tick();
        irq_clear = 2'b01;
        tick();
        irq_clear = 2'b00;
        check("irq_set_wins", 32'(irq_pending), 32'd3);
        irq_clear = 2'b10;
        tick();
        irq_clear = 2'b00;
        check("irq_clear", 32'(irq_pending), 32'd1);
        irq_in[1] = 1'b1;
        repeat (4) tick();
        check("irq_no_rise", 32'(irq_pending), 32'd1);

        sl_word = 8'h99; sl_cpol = 1'b1; sl_cpha = 1'b0; sl_cs = 1'b1;
        arm_req++;
        start = 1'b1; cs_sel = 2'd1; mode = 2'b10; hold_cs = 1'b1; tx_data = 8'hF0;
        tick();
        start = 1'b0;
        repeat (12) tick();
        check("mid_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_done", 32'(done), 32'd0);
        check("arst_rx", 32'(rx_data), 32'd0);
        check("arst_sck", 32'(spi_sck), 32'd0);
        check("arst_mosi", 32'(spi_mosi), 32'd0);
        check("arst_cs_n", 32'(spi_cs_n), 32'd3);
        check("arst_irq", 32'(irq_pending), 32'd0);
        m_held = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        saw_done = 1'b0;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (done) saw_done = 1'b1;
        end
        check("arst_no_done", 32'(saw_done), 32'd0);
        check("arst_idle", 32'(busy), 32'd0);

        do_xfer(1'b0, 2'b01, 1'b0, 8'h3C, 8'hA5, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
